uart_runner_core: RTL and testbench
===================================

UART_RUNNER_CORE -- requirements
Module: uart_runner_core

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate.
REQ-003 SHALL derive localparam CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE using integer division (868 at defaults).
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 rxd_i  input  1  serial receive line, asynchronous to clk_i, idle high.
REQ-007 txd_o  output  1  serial transmit line, idle high.
REQ-008 rx_data_o  output  8  last correctly received byte.
REQ-009 rx_valid_o  output  1  one-cycle pulse: rx_data_o has just been updated.
REQ-010 frame_err_o  output  1  one-cycle pulse: the stop bit was sampled low.
REQ-011 tx_data_i  input  8  byte to transmit.
REQ-012 tx_valid_i  input  1  transmit request.
REQ-013 tx_ready_o  output  1  transmitter can accept a byte.
REQ-014 tx_busy_o  output  1  a frame is in progress on txd_o.
REQ-015 overrun_o  output  1  one-cycle pulse: an echo byte was dropped (echo build only; tied 0 otherwise).

Function
REQ-016 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), each bit lasting CLKS_PER_BIT cycles.
REQ-017 rxd_i SHALL pass through a 2-flop synchroniser whose flops reset to 1.
REQ-018 RX FSM states SHALL be IDLE, START, DATA and STOP.
REQ-019 RX IDLE -> START SHALL occur on a synchronised low level.
REQ-020 RX START SHALL sample at CLKS_PER_BIT/2; a high sample is a glitch and returns to IDLE with no output.
REQ-021 RX DATA SHALL sample each data bit one CLKS_PER_BIT after the previous sample, i.e. at bit centre.
REQ-022 RX STOP SHALL sample at stop-bit centre and return to IDLE in that cycle.
REQ-023 On a high stop sample, rx_data_o SHALL update and rx_valid_o SHALL pulse in the same cycle.
REQ-024 On a low stop sample, frame_err_o SHALL pulse and rx_data_o SHALL hold its previous value.
REQ-025 TX FSM states SHALL be IDLE, START, DATA and STOP.
REQ-026 tx_ready_o SHALL equal (TX state == IDLE); the transmitter accepts a byte on tx_valid_i && tx_ready_o.
REQ-027 The start bit SHALL appear on txd_o in the cycle after acceptance.
REQ-028 tx_ready_o SHALL rise on the cycle after the final stop-bit cycle; back-to-back frames SHALL need no extra idle gap.
REQ-029 tx_valid_i while not ready SHALL be ignored, and the byte SHALL NOT be queued.
REQ-030 RX and TX SHALL operate fully independently, including full-duplex operation at the same time.

Reset
REQ-031 rst_i SHALL be sampled on clk_i edges only.
REQ-032 After reset: txd_o = 1, tx_ready_o = 1, tx_busy_o = 0, rx_data_o = 0x00, and rx_valid_o, frame_err_o and overrun_o are all 0.
REQ-033 Reset asserted mid-frame SHALL abort both FSMs to IDLE, with txd_o high on the next edge.
REQ-034 After such a reset, a partially received frame SHALL NOT produce rx_valid_o.

Configuration
REQ-035 Macro UART_RUNNER_ECHO_EN, when defined: every validly received byte is loaded into a 1-entry echo register and transmitted automatically.
REQ-036 In the echo build, tx_valid_i and tx_data_i SHALL be ignored and tx_ready_o SHALL be held 0.
REQ-037 In the echo build, if a byte arrives while the echo register is full, overrun_o SHALL pulse and the new byte SHALL be dropped; rx_data_o still updates.
REQ-038 Without UART_RUNNER_ECHO_EN, the echo register and the overrun logic SHALL be absent and overrun_o SHALL be tied 0.

Structure
REQ-039 Package uart_runner_pkg SHALL hold the rx_state_e and tx_state_e enums, DATA_BITS = 8, and a function that computes clocks-per-bit.
REQ-040 The transmitter SHALL be the one sub-module, uart_tx; the receiver, synchroniser and echo logic SHALL sit in the top level.

Verification
REQ-041 Bench SHALL run with CLKS_PER_BIT = 16 for speed and repeat one case at the default parameters.
REQ-042 Drive rxd_i with 0x55, 0xAA and 0xF0, idle high between bytes -> exactly three rx_valid_o pulses with rx_data_o = 0x55, 0xAA, 0xF0, and no frame_err_o.
REQ-043 Drive a byte 0x3C with the stop bit held low -> one frame_err_o pulse, no rx_valid_o, and rx_data_o unchanged.
REQ-044 Drive a low glitch on rxd_i shorter than CLKS_PER_BIT/2 -> no outputs, and the RX FSM back in IDLE.
REQ-045 Assert tx_valid_i with tx_data_i = 0xA5 -> txd_o carries 0,1,0,1,0,0,1,0,1,1, each bit exactly CLKS_PER_BIT cycles; tx_ready_o low for 10*CLKS_PER_BIT cycles.
REQ-046 Assert rst_i during bit 4 of an RX frame and a TX frame -> txd_o = 1 and tx_ready_o = 1 on the next edge, and no rx_valid_o.
REQ-047 With UART_RUNNER_ECHO_EN, receive 0x55 -> 0x55 is re-sent on txd_o; a third byte arriving while one frame transmits and one is held -> overrun_o pulse.

Source files
------------

// File: rtl/uart_runner_pkg.sv
// Shared types and helpers for the uart_runner_core slice: FSM state
// enums for both directions, the data width and the bit-period calculation.
package uart_runner_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Number of clk cycles per serial bit, truncated like the hardware divider.
  function automatic int clks_per_bit_calc(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_runner_core_tx.sv
// 8N1 serial transmitter. Accepts a byte when valid && ready, sends the
// start bit in the very next cycle and returns to ready straight after the
// last stop-bit cycle so frames can run back to back.
module uart_tx
  import uart_runner_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= TX_IDLE;
    else       state <= state_next;
  end

  // Bit timer, bit index and shift register; the byte is latched on acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == TX_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (valid) shift <= data;
    end else if (bit_end) begin
      cnt <= '0;
      if (state == TX_DATA) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (valid) state_next = TX_START;
      TX_START: if (bit_end) state_next = TX_DATA;
      TX_DATA:  if (bit_end && (bit_idx == IDX_LAST)) state_next = TX_STOP;
      TX_STOP:  if (bit_end) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // Line level and handshake decoded from the current state.
  always_comb begin
    ready = (state == TX_IDLE);
    busy  = (state != TX_IDLE);
    case (state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = shift[0];
      default:  txd = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_runner_core.sv
// UART core: 2-flop synchronised 8N1 receiver plus the uart_tx transmitter.
// Optional feature macro UART_RUNNER_ECHO_EN: received bytes are held in a
// one-entry echo register and sent back automatically; the host TX port is
// then ignored and overrun_o reports bytes dropped while the register is full.
module uart_runner_core
  import uart_runner_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic                 txd_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 overrun_o
);

  localparam int CLKS_PER_BIT = clks_per_bit_calc(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [1:0]           rx_sync;
  logic                 rxd_s;
  rx_state_e            rx_state, rx_state_next;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 half_hit, bit_hit, stop_ok, stop_bad;

  logic                 tx_valid_int, tx_ready_int;
  logic [DATA_BITS-1:0] tx_data_int;

  assign rxd_s    = rx_sync[1];
  assign half_hit = (rx_cnt == HALF_LAST);
  assign bit_hit  = (rx_cnt == CNT_LAST);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rxd_i};
  end

  // RX state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_next;
  end

  // RX timer and shifter: half a bit to the start centre, then whole bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_START: rx_cnt <= half_hit ? '0 : rx_cnt + 1'b1;
        RX_DATA: begin
          if (bit_hit) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: rx_cnt <= bit_hit ? '0 : rx_cnt + 1'b1;
        default: begin
          rx_cnt <= '0;
          rx_idx <= '0;
        end
      endcase
    end
  end

  // RX next state: a high start-centre sample is a glitch and aborts.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rxd_s) rx_state_next = RX_START;
      RX_START: if (half_hit) rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && (rx_idx == IDX_LAST)) rx_state_next = RX_STOP;
      RX_STOP:  if (bit_hit) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // RX outputs: classify the stop-bit centre sample.
  always_comb begin
    stop_ok  = (rx_state == RX_STOP) && bit_hit && rxd_s;
    stop_bad = (rx_state == RX_STOP) && bit_hit && !rxd_s;
  end

  // Registered result so data and its valid pulse appear together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid_o  <= stop_ok;
      frame_err_o <= stop_bad;
      if (stop_ok) rx_data_o <= rx_shift;
    end
  end

`ifdef UART_RUNNER_ECHO_EN
  logic                 echo_full, tx_accept, unused_host_tx;
  logic [DATA_BITS-1:0] echo_data;

  assign tx_accept      = echo_full && tx_ready_int;
  assign tx_valid_int   = echo_full;
  assign tx_data_int    = echo_data;
  assign tx_ready_o     = 1'b0;
  assign unused_host_tx = ^{tx_data_i, tx_valid_i};

  // Echo register: a new byte is dropped only if the held one is not leaving now.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      echo_full <= 1'b0;
      echo_data <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (stop_ok && echo_full && !tx_accept) begin
        overrun_o <= 1'b1;
      end else if (stop_ok) begin
        echo_full <= 1'b1;
        echo_data <= rx_shift;
      end else if (tx_accept) begin
        echo_full <= 1'b0;
      end
    end
  end
`else
  assign tx_valid_int = tx_valid_i;
  assign tx_data_int  = tx_data_i;
  assign tx_ready_o   = tx_ready_int;
  assign overrun_o    = 1'b0;
`endif

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data (tx_data_int),
    .valid(tx_valid_int),
    .ready(tx_ready_int),
    .busy (tx_busy_o),
    .txd  (txd_o)
  );

endmodule

// File: tb/tb_uart_runner_core.sv
// Self-checking bench for uart_runner_core: a fast instance (16 clocks per
// bit) exercises RX, TX and reset; a default-parameter instance repeats one
// receive. Received frames are checked against a scoreboard queue.
module tb_uart_runner_core;
  import uart_runner_pkg::*;

  localparam int CPB     = 16;
  localparam int CPB_DEF = 868;
`ifdef UART_RUNNER_ECHO_EN
  localparam logic EXP_READY = 1'b0;
`else
  localparam logic EXP_READY = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rxd, txd, rx_valid, frame_err, tx_valid, tx_ready, tx_busy, overrun;
  logic [7:0] rx_data, tx_data;
  logic       rxd_d, txd_d, rx_valid_d, frame_err_d, tx_valid_d, tx_ready_d, tx_busy_d, overrun_d;
  logic [7:0] rx_data_d, tx_data_d;

  uart_runner_core #(.CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115_200)) dut (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd), .txd_o(txd),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .frame_err_o(frame_err),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_busy_o(tx_busy), .overrun_o(overrun));

  uart_runner_core dut_def (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd_d), .txd_o(txd_d),
    .rx_data_o(rx_data_d), .rx_valid_o(rx_valid_d), .frame_err_o(frame_err_d),
    .tx_data_i(tx_data_d), .tx_valid_i(tx_valid_d), .tx_ready_o(tx_ready_d),
    .tx_busy_o(tx_busy_d), .overrun_o(overrun_d));

  typedef struct packed { logic is_err; logic [7:0] data; } rx_exp_t;
  typedef struct packed { logic [7:0] data; logic stop; logic exp_err; logic [7:0] exp_data; } rx_vec_t;

  rx_exp_t exp_q[$];
  rx_exp_t mon_e;
  rx_vec_t vecs[4];
  int total = 0, bad = 0;
  int valid_cnt = 0, err_cnt = 0, ovr_cnt = 0, def_valid_cnt = 0, def_err_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one 8N1 frame; stop_cycles lets a frame end early after the stop centre.
  task automatic applyStimulus(input logic [7:0] b, input logic stop, input int cpb,
                               input int stop_cycles, input bit on_def);
    logic [9:0] frame;
    int n;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      n = (i == 9) ? stop_cycles : cpb;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (on_def) rxd_d = frame[i]; else rxd = frame[i];
      end
    end
    @(negedge clk);
    if (on_def) rxd_d = 1'b1; else rxd = 1'b1;
  endtask

  task automatic captureTx(output logic [7:0] b, output bit seen);
    int waited;
    waited = 0;
    seen = 1'b0;
    b = '0;
    while (txd !== 1'b0 && waited < 20 * CPB) begin
      @(negedge clk);
      waited++;
    end
    if (txd === 1'b0) begin
      seen = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
    end
  endtask

  // Scoreboard monitor: every RX pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      if (rx_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("rx_unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rx_kind", {30'd0, rx_valid, frame_err}, mon_e.is_err ? 32'd1 : 32'd2);
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
      end
    end
    if (overrun) ovr_cnt++;
    if (rx_valid_d) def_valid_cnt++;
    if (frame_err_d) def_err_cnt++;
  end

  initial begin
    logic [0:9] a5_line;
    logic [7:0] cap;
    bit ok, seen;
    int low, v0, e0;
    a5_line = 10'b0101001011;
    rst = 1'b1; rxd = 1'b1; rxd_d = 1'b1;
    tx_valid = 1'b0; tx_data = '0; tx_valid_d = 1'b0; tx_data_d = '0;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_err: 1'b0, exp_data: 8'h55};
    vecs[1] = '{data: 8'hAA, stop: 1'b1, exp_err: 1'b0, exp_data: 8'hAA};
    vecs[2] = '{data: 8'hF0, stop: 1'b1, exp_err: 1'b0, exp_data: 8'hF0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_err: 1'b1, exp_data: 8'hF0};

    repeat (3) @(negedge clk);
    checkOutput("rst_txd", {31'd0, txd}, 32'd1);
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, {31'd0, EXP_READY});
    checkOutput("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("rst_pulses", {29'd0, rx_valid, frame_err, overrun}, 32'd0);
    checkOutput("rst_def_txd", {31'd0, txd_d}, 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Short low glitch must be rejected at the start-bit centre.
    v0 = valid_cnt; e0 = err_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch_pulses", valid_cnt + err_cnt, v0 + e0);
    checkOutput("glitch_rx_idle", 32'(dut.rx_state), 32'(RX_IDLE));

    // Receive table: three good bytes then one with a low stop bit.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{is_err: vecs[i].exp_err, data: vecs[i].exp_data});
      applyStimulus(vecs[i].data, vecs[i].stop, CPB, CPB, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      checkOutput($sformatf("rx_vec%0d_data_out", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
    end
    checkOutput("rx_valid_count", valid_cnt, 3);
    checkOutput("frame_err_count", err_cnt, 1);
    checkOutput("sb_empty_rx", exp_q.size(), 0);

`ifndef UART_RUNNER_ECHO_EN
    // Transmit 0xA5 and check every cycle of every bit.
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_valid = 1'b0;
    checkOutput("tx_busy_after_accept", {31'd0, tx_busy}, 32'd1);
    low = 0;
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (txd !== a5_line[b]) ok = 1'b0;
        if (!tx_ready) low++;
        if (b == 3 && c == 0) begin tx_valid = 1'b1; tx_data = 8'h00; end
        else tx_valid = 1'b0;
        @(negedge clk);
      end
      checkOutput($sformatf("tx_bit%0d", b), {31'd0, ok}, 32'd1);
    end
    checkOutput("tx_ready_back", {31'd0, tx_ready}, 32'd1);
    checkOutput("tx_ready_low_cycles", low, 10 * CPB);
    ok = 1'b1;
    for (int c = 0; c < CPB; c++) begin
      if (txd !== 1'b1 || tx_ready !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("tx_busy_request_dropped", {31'd0, ok}, 32'd1);

    // Back-to-back: a held request starts the next frame with no idle gap.
    tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (10 * CPB + 1) @(negedge clk);
    checkOutput("b2b_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk); tx_valid = 1'b0;
    checkOutput("b2b_start_bit", {30'd0, txd, tx_ready}, 32'd0);
    repeat (10 * CPB) @(negedge clk);
`endif

    // Reset in the middle of simultaneous RX and TX frames.
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h00; rxd = 1'b0;
    for (int c = 1; c < 5 * CPB + 8; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (c == CPB) rxd = 1'b1;
    end
`ifndef UART_RUNNER_ECHO_EN
    checkOutput("busy_before_rst", {31'd0, tx_busy}, 32'd1);
`endif
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_txd", {31'd0, txd}, 32'd1);
    checkOutput("midrst_tx_ready", {31'd0, tx_ready}, {31'd0, EXP_READY});
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("midrst_no_rx_pulse", valid_cnt + err_cnt, v0 + e0);

`ifdef UART_RUNNER_ECHO_EN
    // Echo: a received byte is re-sent.
    exp_q.push_back('{is_err: 1'b0, data: 8'h55});
    fork
      applyStimulus(8'h55, 1'b1, CPB, CPB, 1'b0);
      captureTx(cap, seen);
    join
    checkOutput("echo_seen", {31'd0, seen}, 32'd1);
    checkOutput("echo_byte", {24'd0, cap}, 32'h55);
    repeat (3 * CPB) @(negedge clk);
    // Frames slightly shorter than TX frames build a backlog until a byte drops.
    for (int i = 0; i < 40 && ovr_cnt == 0; i++) begin
      exp_q.push_back('{is_err: 1'b0, data: 8'(i + 1)});
      applyStimulus(8'(i + 1), 1'b1, CPB, 10, 1'b0);
    end
    checkOutput("overrun_seen", {31'd0, ovr_cnt > 0}, 32'd1);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("sb_empty_echo", exp_q.size(), 0);
`endif

    // One receive at the default 868 clocks per bit.
    applyStimulus(8'hA5, 1'b1, CPB_DEF, CPB_DEF, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("def_rx_valid_count", def_valid_cnt, 1);
    checkOutput("def_frame_err_count", def_err_cnt, 0);
    checkOutput("def_rx_data", {24'd0, rx_data_d}, 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
